// File: rtl/legv8_multicycle_ctrl.sv
// Multicycle control FSM for the LEGv8 datapath: sequences fetch, decode, execute,
// memory and write-back over a shared memory port and a single ALU.
module legv8_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_imm,
  output logic [1:0]  alu_op,
  output logic [1:0]  imm_sel,
  output logic        illegal_instr,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_WB_LD  = 4'd7,
    S_MEM_WR = 4'd8,
    S_CBZ    = 4'd9,
    S_BRANCH = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    OP_ILL  = 3'd0,
    OP_R    = 3'd1,
    OP_LDUR = 3'd2,
    OP_STUR = 3'd3,
    OP_CBZ  = 3'd4,
    OP_B    = 3'd5
  } op_t;

  // Same opcode classification the sign-extend unit uses to pick its immediate field.
  function automatic op_t decode_op(input logic [10:0] opc);
    op_t res;
    if (opc[10:5] == 6'b000101) begin
      res = OP_B;
    end else if (opc[10:3] == 8'b10110100) begin
      res = OP_CBZ;
    end else begin
      case (opc)
        11'b11111000010: res = OP_LDUR;
        11'b11111000000: res = OP_STUR;
        11'b10001011000,
        11'b11001011000,
        11'b10001010000,
        11'b10101010000: res = OP_R;
        default:         res = OP_ILL;
      endcase
    end
    return res;
  endfunction

  state_t      state_q;
  state_t      next_state;
  op_t         op;
  logic        instr_unused;

  logic        mem_req_q;
  logic        mem_we_q;
  logic        reg_write_q;
  logic        mem_to_reg_q;
  logic        alu_src_imm_q;
  logic [1:0]  alu_op_q;
  logic        pc_src_q;
  logic        fetch_q;
  logic        cbz_q;
  logic        branch_q;

  assign op           = decode_op(instr[31:21]);
  assign instr_unused = ^instr[20:0];

  always_comb begin
    next_state = S_FETCH;
    case (state_q)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_R:            next_state = S_EXEC_R;
          OP_LDUR, OP_STUR: next_state = S_ADDR;
          OP_CBZ:          next_state = S_CBZ;
          OP_B:            next_state = S_BRANCH;
          default:         next_state = S_FETCH;
        endcase
      end
      S_EXEC_R: next_state = S_WB_R;
      S_ADDR:   next_state = (op == OP_STUR) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: next_state = mem_ready ? S_WB_LD : S_MEM_RD;
      S_MEM_WR: next_state = mem_ready ? S_FETCH : S_MEM_WR;
      default:  next_state = S_FETCH;
    endcase
  end

  // Outputs are decoded from the state being entered so they are registered yet Moore-timed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_op_q      <= 2'b00;
      pc_src_q      <= 1'b0;
      fetch_q       <= 1'b0;
      cbz_q         <= 1'b0;
      branch_q      <= 1'b0;
    end else begin
      state_q       <= next_state;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      alu_src_imm_q <= 1'b0;
      alu_op_q      <= 2'b00;
      pc_src_q      <= 1'b0;
      fetch_q       <= 1'b0;
      cbz_q         <= 1'b0;
      branch_q      <= 1'b0;
      case (next_state)
        S_FETCH: begin
          mem_req_q <= 1'b1;
          fetch_q   <= 1'b1;
        end
        S_EXEC_R: alu_op_q <= 2'b10;
        S_WB_R:   reg_write_q <= 1'b1;
        S_ADDR:   alu_src_imm_q <= 1'b1;
        S_MEM_RD: mem_req_q <= 1'b1;
        S_WB_LD: begin
          reg_write_q  <= 1'b1;
          mem_to_reg_q <= 1'b1;
        end
        S_MEM_WR: begin
          mem_req_q <= 1'b1;
          mem_we_q  <= 1'b1;
        end
        S_CBZ: begin
          alu_op_q <= 2'b01;
          pc_src_q <= 1'b1;
          cbz_q    <= 1'b1;
        end
        S_BRANCH: begin
          pc_src_q <= 1'b1;
          branch_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The IR/PC load at fetch completion and the CBZ take decision depend on same-cycle inputs.
  assign ir_write      = fetch_q & mem_ready;
  assign pc_write      = (fetch_q & mem_ready) | (cbz_q & zero) | branch_q;
  assign illegal_instr = (state_q == S_DECODE) && (op == OP_ILL);

  always_comb begin
    imm_sel = 2'd0;
    if (state_q >= S_DECODE && state_q <= S_BRANCH) begin
      case (op)
        OP_B:    imm_sel = 2'd2;
        OP_CBZ:  imm_sel = 2'd1;
        default: imm_sel = 2'd0;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign pc_src      = pc_src_q;
  assign reg_write   = reg_write_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign alu_src_imm = alu_src_imm_q;
  assign alu_op      = alu_op_q;
  assign state       = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: table of instruction sequences checked cycle by cycle
// through an expected-output queue, plus hand-written reset sequences.
module tb_legv8_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_write, pc_write, pc_src, reg_write;
  logic        mem_to_reg, alu_src_imm, illegal_instr;
  logic [1:0]  alu_op, imm_sel;
  logic [3:0]  state;

  always #5 clk = ~clk;

  legv8_multicycle_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_imm   (alu_src_imm),
    .alu_op        (alu_op),
    .imm_sel       (imm_sel),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic [1:0] imm_sel;
    logic       illegal;
  } obs_t;

  // path holds the zero-wait state sequence, first state in the most significant used nibble.
  typedef struct {
    string       name;
    logic [31:0] ins;
    logic        z;
    int          fw;
    int          mw;
    logic [31:0] path;
    int          len;
  } vec_t;

  obs_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] cur_instr = 32'h0;
  vec_t        tbl[16];

  function automatic vec_t mk(string n, logic [31:0] i, logic z, int fw, int mw,
                              logic [31:0] p, int l);
    vec_t v;
    v.name = n; v.ins = i; v.z = z; v.fw = fw; v.mw = mw; v.path = p; v.len = l;
    return v;
  endfunction

  // 0 illegal, 1 R-type, 2 LDUR, 3 STUR, 4 CBZ, 5 B
  function automatic int classify(logic [31:0] ins);
    if (ins[31:26] == 6'b000101) return 5;
    if (ins[31:24] == 8'b10110100) return 4;
    case (ins[31:21])
      11'b11111000010: return 2;
      11'b11111000000: return 3;
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t model(logic [3:0] s, logic [31:0] ins, logic z, logic rdy);
    obs_t o;
    int   c;
    o = '0;
    o.st = s;
    c = classify(ins);
    if (s >= 4'd2 && s <= 4'd10)
      o.imm_sel = (c == 5) ? 2'd2 : ((c == 4) ? 2'd1 : 2'd0);
    case (s)
      4'd1:  begin o.mem_req = 1'b1; o.ir_write = rdy; o.pc_write = rdy; end
      4'd2:  o.illegal = (c == 0);
      4'd3:  o.alu_op = 2'b10;
      4'd4:  o.reg_write = 1'b1;
      4'd5:  begin o.alu_op = 2'b00; o.alu_src_imm = 1'b1; end
      4'd6:  o.mem_req = 1'b1;
      4'd7:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      4'd8:  begin o.mem_req = 1'b1; o.mem_we = 1'b1; end
      4'd9:  begin o.alu_op = 2'b01; o.pc_src = 1'b1; o.pc_write = z; end
      4'd10: begin o.pc_src = 1'b1; o.pc_write = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("st=%0d req=%b we=%b irw=%b pcw=%b pcs=%b rw=%b m2r=%b asi=%b aop=%b isel=%0d ill=%b",
                     o.st, o.mem_req, o.mem_we, o.ir_write, o.pc_write, o.pc_src, o.reg_write,
                     o.mem_to_reg, o.alu_src_imm, o.alu_op, o.imm_sel, o.illegal);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_now(input string tag);
    obs_t act;
    obs_t exp;
    act.st          = state;
    act.mem_req     = mem_req;
    act.mem_we      = mem_we;
    act.ir_write    = ir_write;
    act.pc_write    = pc_write;
    act.pc_src      = pc_src;
    act.reg_write   = reg_write;
    act.mem_to_reg  = mem_to_reg;
    act.alu_src_imm = alu_src_imm;
    act.alu_op      = alu_op;
    act.imm_sel     = imm_sel;
    act.illegal     = illegal_instr;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: nothing queued, got %s", tag, fmt(act));
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s | want %s", tag, fmt(act), fmt(exp));
    end
  endtask

  task automatic step(input logic [3:0] s, input logic rdy, input logic z,
                      input logic [31:0] ins, input logic rn, input string tag);
    @(posedge clk);
    #1;
    rst_n     = rn;
    mem_ready = rdy;
    zero      = z;
    instr     = ins;
    exp_q.push_back(model(s, ins, z, rdy));
    @(negedge clk);
    check_now(tag);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0]  s;
    logic [31:0] ins;
    int          w;
    for (int k = 0; k < v.len; k++) begin
      s   = v.path[4*(v.len-1-k) +: 4];
      ins = (s == 4'd1) ? cur_instr : v.ins;
      w   = (s == 4'd1) ? v.fw : ((s == 4'd6 || s == 4'd8) ? v.mw : -1);
      if (w >= 0) begin
        for (int j = 0; j < w; j++)
          step(s, 1'b0, rbit(), ins, 1'b1, $sformatf("%s s%0d wait%0d", v.name, s, j));
        step(s, 1'b1, rbit(), ins, 1'b1, $sformatf("%s s%0d", v.name, s));
      end else begin
        step(s, rbit(), (s == 4'd9) ? v.z : rbit(), ins, 1'b1,
             $sformatf("%s s%0d", v.name, s));
      end
    end
    cur_instr = v.ins;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk("ADD",      32'h8B020041, 1'b0, 0, 0, 32'h1234,  4);
    tbl[1]  = mk("SUB",      32'hCB1F03E2, 1'b0, 1, 0, 32'h1234,  4);
    tbl[2]  = mk("AND",      32'h8A030020, 1'b1, 0, 0, 32'h1234,  4);
    tbl[3]  = mk("ORR",      32'hAA0103E1, 1'b0, 3, 0, 32'h1234,  4);
    tbl[4]  = mk("LDUR_w2",  32'hF8400000, 1'b0, 2, 2, 32'h12567, 5);
    tbl[5]  = mk("STUR",     32'hF8000000, 1'b0, 0, 0, 32'h1258,  4);
    tbl[6]  = mk("STUR_w",   32'hF81F83E3, 1'b1, 1, 2, 32'h1258,  4);
    tbl[7]  = mk("CBZ_z1",   32'hB4000060, 1'b1, 0, 0, 32'h129,   3);
    tbl[8]  = mk("CBZ_z0",   32'hB4000060, 1'b0, 0, 0, 32'h129,   3);
    tbl[9]  = mk("B",        32'h14000010, 1'b0, 0, 0, 32'h12A,   3);
    tbl[10] = mk("ILL_ones", 32'hFFFFFFFF, 1'b1, 0, 0, 32'h12,    2);
    tbl[11] = mk("ILL_ldx",  32'hF8200000, 1'b0, 1, 0, 32'h12,    2);
    tbl[12] = mk("ILL_addx", 32'h8B200000, 1'b0, 0, 0, 32'h12,    2);
    tbl[13] = mk("ILL_cbnz", 32'hB5000000, 1'b1, 0, 0, 32'h12,    2);
    tbl[14] = mk("B_neg",    32'h17FFFFFF, 1'b1, 0, 0, 32'h12A,   3);
    tbl[15] = mk("LDUR",     32'hF8408020, 1'b0, 0, 0, 32'h12567, 5);

    rst_n     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    instr     = 32'h0;

    // Held in reset: everything quiet whatever the inputs do.
    for (int i = 0; i < 3; i++)
      step(4'd0, rbit(), rbit(), $urandom(), 1'b0, $sformatf("reset%0d", i));
    step(4'd0, rbit(), rbit(), cur_instr, 1'b1, "release idle");

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset dropped while a store is stalled in MEM_WR.
    step(4'd1, 1'b1, rbit(), cur_instr, 1'b1, "rstwr fetch");
    step(4'd2, rbit(), rbit(), 32'hF8000000, 1'b1, "rstwr decode");
    step(4'd5, rbit(), rbit(), 32'hF8000000, 1'b1, "rstwr addr");
    step(4'd8, 1'b0, rbit(), 32'hF8000000, 1'b1, "rstwr stall0");
    step(4'd8, 1'b0, rbit(), 32'hF8000000, 1'b1, "rstwr stall1");
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(model(4'd0, instr, zero, mem_ready));
    check_now("rstwr async drop");
    step(4'd0, 1'b1, rbit(), 32'hF8000000, 1'b0, "rstwr held");
    step(4'd0, rbit(), rbit(), 32'hF8000000, 1'b1, "rstwr release idle");
    cur_instr = 32'hF8000000;
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
